// File: rtl/baud_tick_gen.sv
// Phase-accumulator baud tick generator: rxTick at the oversampled rate, txTick once per osPhase wrap.
// Optional start-bit phase restart on resync when BAUD_TICK_GEN_RESYNC_EN is defined.
module baud_tick_gen #(
   parameter int CLOCK_RATE         = 100000000,
   parameter int BAUD_RATE          = 9600,
   parameter int RX_OVERSAMPLE_RATE = 16,
   parameter int ACC_WIDTH          = 24
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  enable,
   input  logic                                  inc_load,
   input  logic [ACC_WIDTH-1:0]                  inc_value,
   input  logic                                  resync,
   output logic                                  rxTick,
   output logic                                  txTick,
   output logic [$clog2(RX_OVERSAMPLE_RATE)-1:0] osPhase,
   output logic [ACC_WIDTH-1:0]                  incCurrent
);

   localparam int OS_W = $clog2(RX_OVERSAMPLE_RATE);
   localparam longint unsigned ACC_MOD = 64'd1 << ACC_WIDTH;
   localparam longint unsigned INC_NUM =
      64'(BAUD_RATE) * 64'(RX_OVERSAMPLE_RATE) * ACC_MOD;
   localparam longint unsigned INC_ROUND = (INC_NUM + 64'(CLOCK_RATE) / 2) / 64'(CLOCK_RATE);
   localparam logic [ACC_WIDTH-1:0] INC_DEFAULT = ACC_WIDTH'(INC_ROUND);
   localparam logic [ACC_WIDTH-1:0] ACC_HALF    = ACC_WIDTH'(ACC_MOD / 2);
   localparam logic [OS_W-1:0]      OS_LAST     = OS_W'(RX_OVERSAMPLE_RATE - 1);

   if (RX_OVERSAMPLE_RATE < 2) begin : g_bad_os
      $error("baud_tick_gen: RX_OVERSAMPLE_RATE must be at least 2");
   end
   if (ACC_WIDTH < 8 || ACC_WIDTH > 32) begin : g_bad_width
      $error("baud_tick_gen: ACC_WIDTH must be 8 to 32");
   end
   if (INC_ROUND == 0 || INC_ROUND >= ACC_MOD) begin : g_bad_inc
      $error("baud_tick_gen: default increment out of range for these rates");
   end

   logic                 run_q;
   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] inc;
   logic [ACC_WIDTH:0]   sum;
   logic                 carry;
   logic                 resync_hit;

`ifdef BAUD_TICK_GEN_RESYNC_EN
   assign resync_hit = resync;
`else
   logic unused_resync;
   assign unused_resync = resync;
   assign resync_hit    = 1'b0;
`endif

   // Reset asserts asynchronously; release is retimed so accumulation starts on the 2nd edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) run_q <= 1'b0;
      else        run_q <= 1'b1;
   end

   assign sum   = {1'b0, acc} + {1'b0, inc};
   assign carry = sum[ACC_WIDTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc     <= '0;
         inc     <= INC_DEFAULT;
         osPhase <= '0;
         rxTick  <= 1'b0;
         txTick  <= 1'b0;
      end else if (run_q) begin
         if (inc_load) inc <= inc_value;
         rxTick <= 1'b0;
         txTick <= 1'b0;
         // Restart at mid-phase so the first sample lands half a period later.
         if (resync_hit) begin
            acc     <= ACC_HALF;
            osPhase <= '0;
         end else if (enable) begin
            acc <= sum[ACC_WIDTH-1:0];
            if (carry) begin
               rxTick  <= 1'b1;
               txTick  <= (osPhase == OS_LAST);
               osPhase <= (osPhase == OS_LAST) ? '0 : osPhase + 1'b1;
            end
         end
      end
   end

   assign incCurrent = inc;

endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 Parameter CLOCK_RATE, default 100000000: board clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600: baud rate selected at reset.
REQ-003 Parameter RX_OVERSAMPLE_RATE, default 16: number of rx ticks per tx tick; SHALL be at least 2.
REQ-004 Parameter ACC_WIDTH, default 24: width of the phase accumulator and increment; SHALL be 8 to 32.
REQ-005 clk  input  1  board clock; every register SHALL be clocked on its rising edge.
REQ-006 reset  input  1  asynchronous reset, active-low.
REQ-007 enable  input  1  when high, the generator advances; when low, it freezes.
REQ-008 inc_load  input  1  single-cycle strobe that loads inc_value.
REQ-009 inc_value  input  ACC_WIDTH  new phase increment.
REQ-010 resync  input  1  phase restart, used on an rx start-bit edge.
REQ-011 rxTick  output  1  single-cycle pulse at the oversampled rx rate.
REQ-012 txTick  output  1  single-cycle pulse at the tx baud rate.
REQ-013 osPhase  output  $clog2(RX_OVERSAMPLE_RATE)  current oversample index.
REQ-014 incCurrent  output  ACC_WIDTH  active increment, for readback.

Function
REQ-015 The block SHALL be a numerically controlled oscillator built from an ACC_WIDTH-bit phase accumulator acc and an increment register inc.
REQ-016 INC_DEFAULT SHALL be round(BAUD_RATE*RX_OVERSAMPLE_RATE*2^ACC_WIDTH/CLOCK_RATE), computed at elaboration; for the defaults this SHALL be 25770.
REQ-017 Elaboration SHALL fail if INC_DEFAULT is 0 or is at least 2^ACC_WIDTH.
REQ-018 In each cycle with enable=1 and no resync: acc <= (acc+inc) mod 2^ACC_WIDTH, and rxTick SHALL be registered high in the next cycle if and only if the addition carried out.
REQ-019 rxTick SHALL have 1-cycle latency from the carrying addition and SHALL never be high for two or more consecutive cycles unless inc >= 2^(ACC_WIDTH-1).
REQ-020 On each carry, osPhase SHALL increment, wrapping from RX_OVERSAMPLE_RATE-1 to 0.
REQ-021 txTick SHALL be high in exactly the same cycle as the rxTick whose carry wrapped osPhase to 0.
REQ-022 enable=0: acc and osPhase SHALL hold, rxTick and txTick SHALL be 0, and inc_load SHALL still be honoured.
REQ-023 inc_load=1: inc SHALL take inc_value at that clock edge; the addition in the same cycle SHALL use the old inc; acc SHALL NOT be cleared.
REQ-024 inc=0 SHALL stall tick generation with no error; acc SHALL hold its value.
REQ-025 incCurrent SHALL equal inc at all times.

Reset
REQ-026 reset=0 SHALL asynchronously set acc=0, inc=INC_DEFAULT, osPhase=0, rxTick=0 and txTick=0.
REQ-027 Reset deassertion SHALL be synchronised to clk inside the block; the first accumulate SHALL occur on the second rising edge after deassertion.
REQ-028 Reset asserted mid-operation SHALL abort any pending tick; no tick SHALL be emitted while reset is low.

Configuration
REQ-029 Macro BAUD_TICK_GEN_RESYNC_EN SHALL gate the resync feature.
REQ-030 With BAUD_TICK_GEN_RESYNC_EN defined: resync=1 SHALL set acc=2^(ACC_WIDTH-1) and osPhase=0, and SHALL suppress any carry in that cycle.
REQ-031 Consequently, the first rxTick after resync SHALL fall half a sample period later.
REQ-032 resync SHALL take priority over enable; simultaneous inc_load SHALL still load inc.
REQ-033 Without BAUD_TICK_GEN_RESYNC_EN: the resync port SHALL remain present, SHALL be ignored, and SHALL infer no logic.

Verification
REQ-034 Bench parameters for scenarios 035-039: ACC_WIDTH=8, RX_OVERSAMPLE_RATE=4, and inc loaded with 64 after reset.
REQ-035 Steady state -> rxTick exactly every 4 cycles; txTick every 16 cycles, coincident with rxTick when osPhase returns to 0.
REQ-036 Load inc=96 -> rxTick intervals repeat the pattern 3,3,2 (average 8/3 cycles); incCurrent=96 one cycle after the load.
REQ-037 enable low for 10 cycles mid-count -> no ticks, acc and osPhase frozen; after re-enable, the next tick arrives at the remaining phase distance.
REQ-038 With the macro defined, resync with acc=200 -> osPhase=0 and next rxTick 2 cycles later; without the macro -> timing unchanged.
REQ-039 Assert reset during the cycle a carry occurs -> no rxTick is emitted; after release, incCurrent=INC_DEFAULT and osPhase=0.
